// File: rtl/mem_access_stage.sv
// MEM-stage controller: turns EX/MEM load/store control into a byte-enabled
// request/acknowledge transaction, aligns and extends load data for MEM/WB,
// and stalls the upstream pipeline while a transaction is outstanding.
// The byte-lane logic assumes four 8-bit lanes, so B must stay at 32.
module mem_access_stage #(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] alu_result_in,
  input  logic [B-1:0] r_data2_in,
  input  logic         m_MemRead_in,
  input  logic         m_MemWrite_in,
  input  logic [5:0]   opcode_in,
  output logic         mem_req,
  output logic         mem_we,
  output logic [B-1:0] mem_addr,
  output logic [3:0]   mem_be,
  output logic [B-1:0] mem_wdata,
  input  logic [B-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic [B-1:0] read_data_out,
  output logic         stall_out,
  output logic         misaligned_out
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  state_t         r_state;
  logic           r_req;
  logic           r_we;
  logic [B-1:0]   r_addr;
  logic [3:0]     r_be;
  logic [B-1:0]   r_wdata;
  logic [B-1:0]   r_readData;
  logic [1:0]     r_addrLo;
  size_t          r_size;
  logic           r_signed;
  logic           r_isLoad;

  logic           w_access;
  size_t          w_size;
  logic           w_signed;
  logic           w_aligned;
  logic [3:0]     w_be;
  logic [B-1:0]   w_wdata;
  logic           w_start;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [B-1:0]   w_loadData;

  // Decode the access presented by EX/MEM: size, signedness, alignment, lanes and store data.
  always_comb begin
    w_access = m_MemRead_in | m_MemWrite_in;
    w_size   = SZ_WORD;
    w_signed = 1'b0;
    case (opcode_in)
      OP_LB:  begin w_size = SZ_BYTE; w_signed = 1'b1; end
      OP_LBU: w_size = SZ_BYTE;
      OP_SB:  w_size = SZ_BYTE;
      OP_LH:  begin w_size = SZ_HALF; w_signed = 1'b1; end
      OP_LHU: w_size = SZ_HALF;
      OP_SH:  w_size = SZ_HALF;
      default: w_size = SZ_WORD;
    endcase

    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wdata   = r_data2_in;
    case (w_size)
      SZ_BYTE: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << alu_result_in[1:0];
        w_wdata   = {4{r_data2_in[7:0]}};
      end
      SZ_HALF: begin
        w_aligned = ~alu_result_in[0];
        w_be      = alu_result_in[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{r_data2_in[15:0]}};
      end
      default: begin
        w_aligned = (alu_result_in[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = r_data2_in;
      end
    endcase

    w_start        = (r_state == IDLE) & w_access & w_aligned;
    stall_out      = w_start | (r_state == BUSY);
    misaligned_out = (r_state == IDLE) & w_access & ~w_aligned;
  end

  // Pick the addressed lane(s) of the returned word and extend to full width.
  always_comb begin
    case (r_addrLo)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addrLo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      SZ_BYTE: w_loadData = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      SZ_HALF: w_loadData = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default: w_loadData = mem_rdata;
    endcase
  end

  // Transaction FSM: latch the request in IDLE, wait for ack in BUSY, release the pipeline for one DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
      r_readData <= '0;
      r_addrLo   <= 2'b00;
      r_size     <= SZ_WORD;
      r_signed   <= 1'b0;
      r_isLoad   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_req    <= 1'b1;
            r_we     <= m_MemWrite_in;
            r_addr   <= {alu_result_in[B-1:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_addrLo <= alu_result_in[1:0];
            r_size   <= w_size;
            r_signed <= w_signed;
            r_isLoad <= ~m_MemWrite_in;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            if (r_isLoad) begin
              r_readData <= w_loadData;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_be        = r_be;
  assign mem_wdata     = r_wdata;
  assign read_data_out = r_readData;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a table of load/store vectors with
// hand-computed bus and load results, plus a reset-during-BUSY sequence.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic [31:0] alu_result_in;
  logic [31:0] r_data2_in;
  logic        m_MemRead_in;
  logic        m_MemWrite_in;
  logic [5:0]  opcode_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] read_data_out;
  logic        stall_out;
  logic        misaligned_out;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [5:0]  opcode;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        noReq;
    logic        expMis;
    logic        expWe;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRdo;
  } vec_t;

  vec_t vecs[16];

  mem_access_stage #(.B(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_result_in  (alu_result_in),
    .r_data2_in     (r_data2_in),
    .m_MemRead_in   (m_MemRead_in),
    .m_MemWrite_in  (m_MemWrite_in),
    .opcode_in      (opcode_in),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .read_data_out  (read_data_out),
    .stall_out      (stall_out),
    .misaligned_out (misaligned_out)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a run that never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBus(input string tag, input vec_t v);
    checkOutput({tag, " mem_req"},   {31'd0, mem_req}, 32'd1);
    checkOutput({tag, " mem_we"},    {31'd0, mem_we}, {31'd0, v.expWe});
    checkOutput({tag, " mem_addr"},  mem_addr, v.expAddr);
    checkOutput({tag, " mem_be"},    {28'd0, mem_be}, {28'd0, v.expBe});
    checkOutput({tag, " mem_wdata"}, mem_wdata, v.expWdata);
  endtask

  // Runs one instruction from its IDLE cycle through DONE; returns at the start of the following cycle.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    int    stalls;
    tag = $sformatf("v%0d", idx);
    opcode_in     = v.opcode;
    m_MemRead_in  = v.rd;
    m_MemWrite_in = v.wr;
    alu_result_in = v.addr;
    r_data2_in    = v.wdata;
    mem_ack       = 1'b0;
    mem_rdata     = 32'h0;
    @(negedge clk);
    checkOutput({tag, " misaligned"}, {31'd0, misaligned_out}, {31'd0, v.expMis});
    if (v.noReq) begin
      checkOutput({tag, " idle stall"}, {31'd0, stall_out}, 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, " no req"}, {31'd0, mem_req}, 32'd0);
      checkOutput({tag, " rdata held"}, read_data_out, v.expRdo);
      return;
    end
    checkOutput({tag, " idle stall"}, {31'd0, stall_out}, 32'd1);
    stalls = 1;
    @(posedge clk); #1;
    checkBus({tag, " issue"}, v);
    for (int k = 0; k < v.delay; k++) begin
      @(negedge clk);
      checkOutput({tag, " busy stall"}, {31'd0, stall_out}, 32'd1);
      checkBus({tag, " hold"}, v);
      stalls++;
      @(posedge clk); #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    checkOutput({tag, " ack stall"}, {31'd0, stall_out}, 32'd1);
    stalls++;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    checkOutput({tag, " done stall"}, {31'd0, stall_out}, 32'd0);
    checkOutput({tag, " done req"}, {31'd0, mem_req}, 32'd0);
    checkOutput({tag, " done we"}, {31'd0, mem_we}, 32'd0);
    checkOutput({tag, " read_data_out"}, read_data_out, v.expRdo);
    checkOutput({tag, " stall cycles"}, stalls, v.delay + 2);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t lastVec;

    //            op    rd wr addr   wdata          rdata          dly noR mis we  expAddr  be    expWdata       expRdo
    vecs[0]  = '{6'h23, 1, 0, 32'h10, 32'h0,         32'hDEADBEEF, 0, 0, 0, 0, 32'h10, 4'hF, 32'h0,         32'hDEADBEEF};
    vecs[1]  = '{6'h20, 1, 0, 32'h13, 32'h0,         32'h80123456, 0, 0, 0, 0, 32'h10, 4'h8, 32'h0,         32'hFFFFFF80};
    vecs[2]  = '{6'h24, 1, 0, 32'h13, 32'h0,         32'h80123456, 0, 0, 0, 0, 32'h10, 4'h8, 32'h0,         32'h00000080};
    vecs[3]  = '{6'h29, 0, 1, 32'h06, 32'h1234ABCD,  32'h55555555, 2, 0, 0, 1, 32'h04, 4'hC, 32'hABCDABCD,  32'h00000080};
    vecs[4]  = '{6'h23, 1, 0, 32'h02, 32'h0,         32'h0,        0, 1, 1, 0, 32'h0,  4'h0, 32'h0,         32'h00000080};
    vecs[5]  = '{6'h00, 0, 0, 32'h40, 32'h0,         32'h0,        0, 1, 0, 0, 32'h0,  4'h0, 32'h0,         32'h00000080};
    vecs[6]  = '{6'h2B, 0, 1, 32'h20, 32'hCAFEF00D,  32'h0,        0, 0, 0, 1, 32'h20, 4'hF, 32'hCAFEF00D,  32'h00000080};
    vecs[7]  = '{6'h25, 1, 0, 32'h22, 32'h0,         32'h80017FFF, 0, 0, 0, 0, 32'h20, 4'hC, 32'h0,         32'h00008001};
    vecs[8]  = '{6'h21, 1, 0, 32'h22, 32'h0,         32'h80017FFF, 1, 0, 0, 0, 32'h20, 4'hC, 32'h0,         32'hFFFF8001};
    vecs[9]  = '{6'h21, 1, 0, 32'h20, 32'h0,         32'h12348765, 0, 0, 0, 0, 32'h20, 4'h3, 32'h0,         32'hFFFF8765};
    vecs[10] = '{6'h20, 1, 0, 32'h21, 32'h0,         32'h00007F00, 0, 0, 0, 0, 32'h20, 4'h2, 32'h0,         32'h0000007F};
    vecs[11] = '{6'h28, 0, 1, 32'h03, 32'h000000A5,  32'h0,        0, 0, 0, 1, 32'h00, 4'h8, 32'hA5A5A5A5,  32'h0000007F};
    vecs[12] = '{6'h21, 1, 0, 32'h01, 32'h0,         32'h0,        0, 1, 1, 0, 32'h0,  4'h0, 32'h0,         32'h0000007F};
    vecs[13] = '{6'h2B, 1, 1, 32'h08, 32'h11223344,  32'h0,        0, 0, 0, 1, 32'h08, 4'hF, 32'h11223344,  32'h0000007F};
    vecs[14] = '{6'h3F, 1, 0, 32'h0C, 32'h0,         32'h89ABCDEF, 0, 0, 0, 0, 32'h0C, 4'hF, 32'h0,         32'h89ABCDEF};
    vecs[15] = '{6'h20, 1, 0, 32'h12, 32'h0,         32'h00AB0000, 0, 0, 0, 0, 32'h10, 4'h4, 32'h0,         32'hFFFFFFAB};

    reset         = 1'b1;
    alu_result_in = 32'h0;
    r_data2_in    = 32'h0;
    m_MemRead_in  = 1'b0;
    m_MemWrite_in = 1'b0;
    opcode_in     = 6'h0;
    mem_rdata     = 32'h0;
    mem_ack       = 1'b0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset read_data_out", read_data_out, 32'd0);
    checkOutput("reset stall", {31'd0, stall_out}, 32'd0);
    checkOutput("reset misaligned", {31'd0, misaligned_out}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset while BUSY, then a stray ack after reset.
    opcode_in     = 6'h23;
    m_MemRead_in  = 1'b1;
    m_MemWrite_in = 1'b0;
    alu_result_in = 32'h30;
    @(posedge clk); #1;
    checkOutput("midrst issue req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    reset        = 1'b1;
    m_MemRead_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("midrst mem_addr", mem_addr, 32'd0);
    checkOutput("midrst mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("midrst read_data_out", read_data_out, 32'd0);
    checkOutput("midrst stall", {31'd0, stall_out}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("late ack read_data_out", read_data_out, 32'd0);
    checkOutput("late ack mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("late ack stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;

    lastVec = '{6'h23, 1, 0, 32'h44, 32'h0, 32'h0BADF00D, 1, 0, 0, 0, 32'h44, 4'hF, 32'h0, 32'h0BADF00D};
    applyStimulus(16, lastVec);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller fed directly by the EX/MEM pipeline register outputs.
- Turns load/store control (opcode, MemRead, MemWrite, ALU address, store data) into a byte-enabled request/acknowledge transaction on the external data-memory port.
- Aligns and sign/zero-extends load data for the MEM/WB register.
- Drives a stall that holds the upstream pipeline registers while a transaction is outstanding.

Parameters:
- B, 32, data/address width (fixed 4 byte lanes; B must be 32)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- alu_result_in  in  B  effective address from EX/MEM
- r_data2_in  in  B  store data from EX/MEM
- m_MemRead_in  in  1  load request
- m_MemWrite_in  in  1  store request
- opcode_in  in  6  instruction opcode from EX/MEM
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  B  word address, {alu_result_in[B-1:2],2'b00}, registered
- mem_be  out  4  byte enables, lane i = bits [8i+7:8i], registered
- mem_wdata  out  B  lane-replicated store data, registered
- mem_rdata  in  B  read data, valid when mem_ack=1
- mem_ack  in  1  transaction complete
- read_data_out  out  B  aligned/extended load result for MEM/WB, registered
- stall_out  out  1  1 = hold PC, IF/ID, ID/EX and EX/MEM (drives their ena low)
- misaligned_out  out  1  current access is misaligned, combinational

Behaviour:
- Opcodes:
  - LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
  - Any other opcode with MemRead/MemWrite set is treated as a word access.
- access = m_MemRead_in | m_MemWrite_in. When both are set, write wins.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte is always aligned.
- misaligned_out = (state==IDLE) & access & alignment fail.
  - A misaligned access issues no request and no stall.
  - read_data_out holds its value.
- Byte enables (little-endian lanes):
  - Byte: 4'b0001 << addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
  - Applied to loads and stores.
- Store data:
  - SB replicates r_data2_in[7:0] to all four lanes.
  - SH replicates [15:0] to both halves.
  - SW passes data through.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - If access & aligned: latch mem_addr/mem_be/mem_we/mem_wdata, set mem_req=1, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - Hold all mem_* outputs stable.
    - On mem_ack=1: drop mem_req and mem_we, go to DONE.
    - If the access is a load, also register read_data_out from mem_rdata.
  - DONE:
    - One cycle with stall_out=0, so the pipeline advances and MEM/WB captures read_data_out.
    - Go to IDLE.
- stall_out = (IDLE & access & aligned) | BUSY. It is combinational and 0 in DONE.
- Latency and back-to-back:
  - Minimum access is 3 cycles (IDLE, BUSY with same-cycle ack, DONE), giving 2 stall cycles.
  - Each extra BUSY cycle without ack adds one stall cycle.
  - The next instruction is evaluated in the IDLE cycle after DONE.
- Load extraction:
  - Select the lane(s) by addr[1:0] of the latched address.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes data through.
  - Stores leave read_data_out unchanged.
- mem_ack in IDLE or DONE is ignored, including a late ack arriving after reset.
- Reset, including mid-transaction:
  - State goes to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, read_data_out=0.
  - stall_out and misaligned_out are 0 unless a new access is presented after reset.

Test Plan:
- Reset, then LW (0x23) at addr 0x10 with ack on the first BUSY cycle, mem_rdata=0xDEADBEEF:
  - mem_req=1, mem_be=1111, mem_addr=0x10.
  - stall_out high for 2 cycles.
  - read_data_out=0xDEADBEEF in the DONE cycle.
- LB at 0x13 with rdata=0x80xxxxxx returns 0xFFFFFF80; LBU at the same address returns 0x00000080. mem_be=1000 for both.
- SH at 0x06 with r_data2_in=0x1234ABCD, ack delayed 3 cycles:
  - mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, all held stable for 3 cycles.
  - stall_out high for 4 cycles.
  - read_data_out unchanged.
- LW at 0x02:
  - misaligned_out=1, no mem_req, stall_out=0.
  - read_data_out keeps its previous value.
- Reset asserted while in BUSY, then mem_ack pulsed one cycle after reset:
  - Outputs return to 0 and the state goes to IDLE.
  - The late ack causes no state change and no read_data_out update.
- Non-memory op (MemRead=MemWrite=0) immediately after DONE, followed by back-to-back SW then LHU:
  - The non-memory op causes no stall and no request.
  - Two separate 3-cycle transactions occur, with an IDLE cycle between DONE and the next request.
